// File: rtl/panel_bus_pkg.sv
// Shared definitions for the ledpanel control write bus.
// Used by panel_write_arbiter and by every writer that drives the bus
// (udp_panel_writer, local test-pattern/status writers).
package panel_bus_pkg;

    localparam int NUM_PANELS   = 9;   // panel enable mask width
    localparam int PANEL_SEL_W  = 3;   // colour-memory select width
    localparam int PANEL_ADDR_W = 16;  // panel write address width
    localparam int PANEL_DATA_W = 24;  // [R][G][B], 8 bits each

    // Arbiter ownership state: nobody owns the bus, or one writer does.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/panel_write_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Returns the first set bit of req searching upward from ptr with wrap,
// as a one-hot vector, plus a flag telling whether any bit was set.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             found
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the candidates in priority order ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves a signal unassigned infers a latch.
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter: shares the ledpanel control write bus between NUM_REQ
// writers with round-robin ownership. An owner may hold req_lock to keep the
// bus across a multi-beat burst so panels never see interleaved frames.
// Configuration macro: PANEL_ARB_TIMEOUT_EN -- when defined, a locked owner
// that sends no beat for TIMEOUT consecutive cycles is forcibly released and
// timeout_err pulses; when undefined a locked owner holds the bus indefinitely.
module panel_write_arbiter
    import panel_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_PANELS = panel_bus_pkg::NUM_PANELS,
    parameter int ADDR_W     = PANEL_ADDR_W,
    parameter int DATA_W     = PANEL_DATA_W,
    parameter int SEL_W      = PANEL_SEL_W,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*NUM_PANELS-1:0] req_en,
    input  logic [NUM_REQ*SEL_W-1:0]     req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdat,
    output logic [NUM_PANELS-1:0]        ctrl_en,
    output logic [SEL_W-1:0]             ctrl_wr,
    output logic [ADDR_W-1:0]            ctrl_addr,
    output logic [DATA_W-1:0]            ctrl_wdat,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("panel_write_arbiter: NUM_REQ must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("panel_write_arbiter: TIMEOUT must be 1..65535");
    end

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [NUM_PANELS-1:0] ctrl_en_q, ctrl_en_d;
    logic [SEL_W-1:0]    ctrl_wr_q, ctrl_wr_d;
    logic [ADDR_W-1:0]   ctrl_addr_q, ctrl_addr_d;
    logic [DATA_W-1:0]   ctrl_wdat_q, ctrl_wdat_d;
    logic                timeout_err_q, timeout_err_d;
`ifdef PANEL_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0]         idle_cnt_q, idle_cnt_d;
`endif

    // Current owner's request, selected by the registered grant.
    logic [PTR_W-1:0]      owner_idx;
    logic                  own_valid;
    logic                  own_lock;
    logic [NUM_PANELS-1:0] own_en;
    logic [SEL_W-1:0]      own_wr;
    logic [ADDR_W-1:0]     own_addr;
    logic [DATA_W-1:0]     own_wdat;
    logic [PTR_W-1:0]      rr_next;
    logic                  rel;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic                  pick_found;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_q),
        .winner (pick_onehot),
        .found  (pick_found)
    );

    // Only the granted requester is ever visible to the arbiter.
    always_comb begin
        owner_idx = '0;
        own_valid = 1'b0;
        own_lock  = 1'b0;
        own_en    = '0;
        own_wr    = '0;
        own_addr  = '0;
        own_wdat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = owner_idx | PTR_W'(i);
                own_valid = own_valid | req_valid[i];
                own_lock  = own_lock  | req_lock[i];
                own_en    = own_en    | req_en[i*NUM_PANELS +: NUM_PANELS];
                own_wr    = own_wr    | req_wr[i*SEL_W +: SEL_W];
                own_addr  = own_addr  | req_addr[i*ADDR_W +: ADDR_W];
                own_wdat  = own_wdat  | req_wdat[i*DATA_W +: DATA_W];
            end
        end
        rr_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    end

    // Ownership FSM next state: grant in IDLE, accept beats and release in OWN.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        ctrl_en_d     = '0;
        ctrl_wr_d     = ctrl_wr_q;
        ctrl_addr_d   = ctrl_addr_q;
        ctrl_wdat_d   = ctrl_wdat_q;
        timeout_err_d = 1'b0;
        rel           = 1'b0;
`ifdef PANEL_ARB_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
`ifdef PANEL_ARB_TIMEOUT_EN
                idle_cnt_d = '0;
`endif
                if (pick_found) begin
                    grant_d = pick_onehot;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (own_valid) begin
                    // Owner is always ready while granted, so valid means accepted.
                    ctrl_en_d   = own_en;
                    ctrl_wr_d   = own_wr;
                    ctrl_addr_d = own_addr;
                    ctrl_wdat_d = own_wdat;
                    rel         = !own_lock;
`ifdef PANEL_ARB_TIMEOUT_EN
                    idle_cnt_d  = '0;
`endif
                end else if (!own_lock) begin
                    rel = 1'b1;
`ifdef PANEL_ARB_TIMEOUT_EN
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    rel           = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
`endif
                end
                if (rel) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    rr_d    = rr_next;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any burst at once.
    always_ff @(posedge clock) begin
        // NOTE: flops use non-blocking assignment so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            rr_q          <= '0;
            ctrl_en_q     <= '0;
            ctrl_wr_q     <= '0;
            ctrl_addr_q   <= '0;
            ctrl_wdat_q   <= '0;
            timeout_err_q <= 1'b0;
`ifdef PANEL_ARB_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_wr_q     <= ctrl_wr_d;
            ctrl_addr_q   <= ctrl_addr_d;
            ctrl_wdat_q   <= ctrl_wdat_d;
            timeout_err_q <= timeout_err_d;
`ifdef PANEL_ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign req_ready   = grant_q;
    assign grant       = grant_q;
    assign ctrl_en     = ctrl_en_q;
    assign ctrl_wr     = ctrl_wr_q;
    assign ctrl_addr   = ctrl_addr_q;
    assign ctrl_wdat   = ctrl_wdat_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Self-checking bench for panel_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the ownership rules.
module tb_panel_write_arbiter;

    localparam int NR = 2;
    localparam int NP = 9;
    localparam int AW = 16;
    localparam int DW = 24;
    localparam int SW = 3;
    localparam int TO = 16;
`ifdef PANEL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid, req_lock, req_ready, grant;
    logic [NR*NP-1:0]   req_en;
    logic [NR*SW-1:0]   req_wr;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdat;
    logic [NP-1:0]      ctrl_en;
    logic [SW-1:0]      ctrl_wr;
    logic [AW-1:0]      ctrl_addr;
    logic [DW-1:0]      ctrl_wdat;
    logic               timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    panel_write_arbiter #(
        .NUM_REQ(NR), .NUM_PANELS(NP), .ADDR_W(AW), .DATA_W(DW),
        .SEL_W(SW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_lock(req_lock), .req_ready(req_ready),
        .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_wdat(req_wdat),
        .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner is an integer (-1 = nobody); the model applies the ownership rules
    // directly to the inputs seen at each rising edge.
    int            m_owner = -1;
    int            m_rr    = 0;
    int            m_idle  = 0;
    int            m_c;
    bit            m_rel;
    bit            started = 1'b0;
    logic [NP-1:0] e_en;
    logic [SW-1:0] e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat;
    logic          e_terr;
    logic [NR-1:0] e_grant;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1; m_rr = 0; m_idle = 0;
            e_en = '0; e_wr = '0; e_addr = '0; e_wdat = '0; e_terr = 1'b0;
            started = 1'b1;
        end else begin
            e_en   = '0;
            e_terr = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < NR; k++) begin
                    m_c = (m_rr + k) % NR;
                    if (m_owner < 0 && req_valid[m_c]) m_owner = m_c;
                end
                m_idle = 0;
            end else begin
                m_rel = 1'b0;
                if (req_valid[m_owner]) begin
                    e_en   = req_en[m_owner*NP +: NP];
                    e_wr   = req_wr[m_owner*SW +: SW];
                    e_addr = req_addr[m_owner*AW +: AW];
                    e_wdat = req_wdat[m_owner*DW +: DW];
                    m_idle = 0;
                    m_rel  = !req_lock[m_owner];
                end else if (!req_lock[m_owner]) begin
                    m_rel = 1'b1;
                end else begin
                    m_idle++;
                    if (TO_EN && m_idle == TO) begin
                        m_rel  = 1'b1;
                        e_terr = 1'b1;
                    end
                end
                if (m_rel) begin
                    m_rr    = (m_owner + 1) % NR;
                    m_owner = -1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (started) begin
            e_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
            check("grant", grant, e_grant);
            check("req_ready", req_ready, e_grant);
            check("ctrl_en", ctrl_en, e_en);
            check("ctrl_wr", ctrl_wr, e_wr);
            check("ctrl_addr", ctrl_addr, e_addr);
            check("ctrl_wdat", ctrl_wdat, e_wdat);
            check("timeout_err", timeout_err, e_terr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int i, input logic v, input logic l, input logic [NP-1:0] en,
                         input logic [SW-1:0] wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_lock[i]          = l;
        req_en[i*NP +: NP]   = en;
        req_wr[i*SW +: SW]   = wr;
        req_addr[i*AW +: AW] = a;
        req_wdat[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        req_valid = '0; req_lock = '0; req_en = '0;
        req_wr = '0; req_addr = '0; req_wdat = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int pv, input int pl);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            reset = ($urandom_range(499) == 0);
            for (int i = 0; i < NR; i++) begin
                drive(i, $urandom_range(99) < pv, $urandom_range(99) < pl,
                      NP'($urandom), SW'($urandom), AW'($urandom), DW'($urandom));
            end
        end
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        clear_all();
        repeat (2) @(negedge clock);

        // Single requester: grant on cycle 1, beat on cycle 2, released.
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 9'h001, 3'd1, 16'h0010, 24'hFF0000);
        @(negedge clock);
        check("single_grant", grant, 2'b01);
        check("single_ready", req_ready, 2'b01);
        check("single_no_beat_yet", ctrl_en, 9'h000);
        @(negedge clock);
        check("single_en", ctrl_en, 9'h001);
        check("single_wr", ctrl_wr, 3'd1);
        check("single_addr", ctrl_addr, 16'h0010);
        check("single_wdat", ctrl_wdat, 24'hFF0000);
        check("single_released", grant, 2'b00);
        drive(0, 1'b0, 1'b0, 9'h000, 3'd0, 16'h0000, 24'h000000);
        @(negedge clock);
        check("single_en_drop", ctrl_en, 9'h000);

        // Contention: round robin with one IDLE bubble per ownership change.
        do_reset();
        drive(0, 1'b1, 1'b0, 9'h003, 3'd2, 16'h1111, 24'h0000AA);
        drive(1, 1'b1, 1'b0, 9'h1C0, 3'd3, 16'h2222, 24'h00BB00);
        @(negedge clock); check("cont_g1", grant, 2'b01);
        @(negedge clock); check("cont_g2", grant, 2'b00); check("cont_en0", ctrl_en, 9'h003);
        @(negedge clock); check("cont_g3", grant, 2'b10);
        @(negedge clock); check("cont_g4", grant, 2'b00); check("cont_addr1", ctrl_addr, 16'h2222);
        @(negedge clock); check("cont_g5", grant, 2'b01);
        clear_all();
        repeat (2) @(negedge clock);

        // Locked burst: 64 uninterrupted beats from req1 while req0 waits.
        do_reset();
        drive(1, 1'b1, 1'b1, 9'h1FF, 3'd2, 16'd0, 24'd1);
        @(negedge clock);
        check("burst_grant1", grant, 2'b10);
        drive(0, 1'b1, 1'b0, 9'h00F, 3'd4, 16'hDEAD, 24'hCAFE00);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            check("burst_en", ctrl_en, 9'h1FF);
            check("burst_addr", ctrl_addr, 16'(k - 1));
            check("burst_owner", grant, (k < 64) ? 2'b10 : 2'b00);
            if (k < 64) drive(1, 1'b1, k != 63, 9'h1FF, 3'd2, 16'(k), 24'(k * 3 + 1));
            else        drive(1, 1'b0, 1'b0, 9'h000, 3'd0, 16'd0, 24'd0);
        end
        @(negedge clock);
        check("burst_then_req0", grant, 2'b01);
        clear_all();
        repeat (2) @(negedge clock);

        // Locked owner goes quiet: forced release after TO idle cycles if enabled.
        do_reset();
        drive(0, 1'b1, 1'b1, 9'h010, 3'd0, 16'h0100, 24'h000001);
        drive(1, 1'b1, 1'b0, 9'h020, 3'd1, 16'h0200, 24'h000002);
        @(negedge clock); check("to_grant0", grant, 2'b01);
        @(negedge clock); check("to_beat", ctrl_en, 9'h010);
        req_valid[0] = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            @(negedge clock);
            if (TO_EN && j == TO) begin
                check("to_err_pulse", timeout_err, 1'b1);
                check("to_released", grant, 2'b00);
            end else begin
                check("to_err_quiet", timeout_err, 1'b0);
                check("to_held", grant, 2'b01);
            end
        end
        @(negedge clock);
        check("to_after", grant, TO_EN ? 2'b10 : 2'b01);
        check("to_err_once", timeout_err, 1'b0);
        clear_all();
        repeat (3) @(negedge clock);

        // Zero-enable beat: handshake completes, no panel strobed, address moves.
        do_reset();
        drive(0, 1'b1, 1'b0, 9'h000, 3'd5, 16'hBEEF, 24'h123456);
        @(negedge clock); check("zero_ready", req_ready, 2'b01);
        @(negedge clock);
        check("zero_en", ctrl_en, 9'h000);
        check("zero_addr", ctrl_addr, 16'hBEEF);
        check("zero_wdat", ctrl_wdat, 24'h123456);
        check("zero_released", grant, 2'b00);
        clear_all();
        repeat (2) @(negedge clock);

        // Reset in the middle of a locked burst.
        do_reset();
        drive(1, 1'b1, 1'b1, 9'h1FF, 3'd6, 16'h0A00, 24'h0F0F0F);
        @(negedge clock); check("rst_burst_grant", grant, 2'b10);
        drive(0, 1'b1, 1'b0, 9'h001, 3'd1, 16'h0B00, 24'h111111);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            drive(1, 1'b1, 1'b1, 9'h1FF, 3'd6, 16'h0A01 + 16'(k), 24'h0F0F0F);
        end
        reset = 1'b1;
        @(negedge clock);
        check("rst_en", ctrl_en, 9'h000);
        check("rst_grant", grant, 2'b00);
        check("rst_ready", req_ready, 2'b00);
        check("rst_addr", ctrl_addr, 16'h0000);
        check("rst_wdat", ctrl_wdat, 24'h000000);
        check("rst_wr", ctrl_wr, 3'd0);
        check("rst_terr", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_resume_rr0", grant, 2'b01);
        clear_all();
        repeat (2) @(negedge clock);

        // Randomized traffic with different valid/lock densities.
        random_phase(1500, 60, 50);
        random_phase(1500, 30, 85);
        random_phase(1500, 95, 90);
        clear_all();
        repeat (4) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
